// File: rtl/multi_edge_event_monitor_if.sv
// Port bundle for multi_edge_event_monitor: monitored pins, per-channel edge
// configuration and clear in; pulse/stretch/sticky/count status and stretch-FSM debug view out.
interface multi_edge_event_monitor_if #(
    parameter int CH_NUM = 8,
    parameter int DLY_W  = 16,
    parameter int CNT_W  = 8
);
    logic [CH_NUM-1:0]       iSig;
    logic [CH_NUM-1:0]       iEdge_pos;
    logic [CH_NUM-1:0]       iEdge_neg;
    logic [DLY_W-1:0]        iDelay_time;
    logic [CH_NUM-1:0]       iClear;
    logic [CH_NUM-1:0]       oPulse;
    logic [CH_NUM-1:0]       oExt_pulse;
    logic [CH_NUM-1:0]       oSticky;
    logic [CH_NUM*CNT_W-1:0] oEvt_cnt;
    logic                    oAny_event;
    // One bit per channel, set while that channel's stretch FSM is in STRETCH.
    logic [CH_NUM-1:0]       oDbg_stretch;

    modport master (
        output iSig, iEdge_pos, iEdge_neg, iDelay_time, iClear,
        input  oPulse, oExt_pulse, oSticky, oEvt_cnt, oAny_event, oDbg_stretch
    );

    modport slave (
        input  iSig, iEdge_pos, iEdge_neg, iDelay_time, iClear,
        output oPulse, oExt_pulse, oSticky, oEvt_cnt, oAny_event, oDbg_stretch
    );
endinterface

// File: rtl/multi_edge_event_monitor.sv
// Multi-channel edge monitor: sync, edge detect, 1-cycle pulse, retriggerable stretch,
// sticky flag and saturating count. Define EDGE_DEBOUNCE_EN to add the DB_CNT-cycle debounce stage.
module multi_edge_event_monitor #(
    parameter int CH_NUM = 8,
    parameter int DLY_W  = 16,
    parameter int CNT_W  = 8
`ifdef EDGE_DEBOUNCE_EN
    , parameter int DB_CNT = 3
`endif
) (
    input  logic                     iClk_1ms,
    input  logic                     iRst_n,
    multi_edge_event_monitor_if.slave bus
);
    typedef enum logic {ST_IDLE = 1'b0, ST_STRETCH = 1'b1} st_t;

    // Edges stay suppressed until the synchronizer (and debounce register) hold real pin data.
`ifdef EDGE_DEBOUNCE_EN
    localparam logic [2:0] SEED_LEN = 3'd4;
`else
    localparam logic [2:0] SEED_LEN = 3'd3;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CH_NUM-1:0] sync1, sync2, lvl, prev, evt;
    logic [CH_NUM-1:0] pulse_q, sticky_q, ext;
    logic [CNT_W-1:0]  cnt_q [CH_NUM];
    logic [2:0]        seed_cnt;
    logic              seed, any_q;
    logic [DLY_W-1:0]  dly_load;

    always_ff @(posedge iClk_1ms or negedge iRst_n) begin
        if (!iRst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            seed_cnt <= SEED_LEN;
        end else begin
            sync1 <= bus.iSig;
            sync2 <= sync1;
            prev  <= lvl;
            if (seed_cnt != 3'd0) seed_cnt <= seed_cnt - 3'd1;
        end
    end

    assign seed = (seed_cnt != 3'd0);

`ifdef EDGE_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CNT + 1);
    logic [DB_W-1:0]   db_cnt [CH_NUM];
    logic [CH_NUM-1:0] db_lvl;

    always_ff @(posedge iClk_1ms or negedge iRst_n) begin
        if (!iRst_n) begin
            db_lvl <= '0;
            for (int i = 0; i < CH_NUM; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (seed) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else if (sync2[i] != db_lvl[i]) begin
                    if (db_cnt[i] == DB_W'(DB_CNT - 1)) begin
                        db_lvl[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign lvl = db_lvl;
`else
    assign lvl = sync2;
`endif

    assign evt = {CH_NUM{~seed}} &
                 ((lvl & ~prev & bus.iEdge_pos) | (~lvl & prev & bus.iEdge_neg));

    // A zero stretch length still gives a one-cycle stretched pulse.
    assign dly_load = (bus.iDelay_time == '0) ? '0 : bus.iDelay_time - DLY_W'(1);

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        st_t              state, state_nxt;
        logic [DLY_W-1:0] tmr, tmr_nxt;

        always_ff @(posedge iClk_1ms or negedge iRst_n) begin
            if (!iRst_n) begin
                state <= ST_IDLE;
                tmr   <= '0;
            end else begin
                state <= state_nxt;
                tmr   <= tmr_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            tmr_nxt   = tmr;
            case (state)
                ST_IDLE: begin
                    if (evt[g]) begin
                        state_nxt = ST_STRETCH;
                        tmr_nxt   = dly_load;
                    end
                end
                ST_STRETCH: begin
                    if (evt[g])            tmr_nxt   = dly_load;
                    else if (tmr != '0)    tmr_nxt   = tmr - DLY_W'(1);
                    else                   state_nxt = ST_IDLE;
                end
            endcase
        end

        assign ext[g] = (state == ST_STRETCH);
        assign bus.oEvt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    // Clear and a same-cycle event resolve in favour of the event.
    always_ff @(posedge iClk_1ms or negedge iRst_n) begin
        if (!iRst_n) begin
            pulse_q  <= '0;
            sticky_q <= '0;
            any_q    <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) cnt_q[i] <= '0;
        end else begin
            pulse_q  <= evt;
            sticky_q <= evt | (sticky_q & ~bus.iClear);
            any_q    <= |sticky_q;
            for (int i = 0; i < CH_NUM; i++) begin
                if (bus.iClear[i])
                    cnt_q[i] <= evt[i] ? CNT_W'(1) : '0;
                else if (evt[i] && cnt_q[i] != CNT_MAX)
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign bus.oPulse       = pulse_q;
    assign bus.oExt_pulse   = ext;
    assign bus.oSticky      = sticky_q;
    assign bus.oAny_event   = any_q;
    assign bus.oDbg_stretch = ext;
endmodule

// File: tb/tb_multi_edge_event_monitor.sv
// Bench for multi_edge_event_monitor: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a history-based reference model.
module tb_multi_edge_event_monitor;
    localparam int CH = 8;
    localparam int DW = 16;
    localparam int CW = 8;
`ifdef EDGE_DEBOUNCE_EN
    localparam int DBN      = 3;
    localparam int SEEDN    = 4;
    localparam int PULSE_AT = 5;
`else
    localparam int SEEDN    = 3;
    localparam int PULSE_AT = 2;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    multi_edge_event_monitor_if #(.CH_NUM(CH), .DLY_W(DW), .CNT_W(CW)) bus ();

    multi_edge_event_monitor #(.CH_NUM(CH), .DLY_W(DW), .CNT_W(CW)) dut (
        .iClk_1ms (clk),
        .iRst_n   (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Level seen by edge detection at edge n is the pin sampled at edge n-2.
    logic [CH-1:0] samp[$];
    int            ext_left [CH];
    logic [CH-1:0] m_pulse, m_sticky;
    logic [CW-1:0] m_cnt [CH];
    logic          m_any;
`ifdef EDGE_DEBOUNCE_EN
    logic [CH-1:0] db_lvl, db_prev;
    int            db_run [CH];
`endif

    task automatic model_reset();
        samp.delete();
        m_pulse  = '0;
        m_sticky = '0;
        m_any    = 1'b0;
        for (int i = 0; i < CH; i++) begin
            ext_left[i] = 0;
            m_cnt[i]    = '0;
        end
`ifdef EDGE_DEBOUNCE_EN
        db_lvl  = '0;
        db_prev = '0;
        for (int i = 0; i < CH; i++) db_run[i] = 0;
`endif
    endtask

    task automatic model_step();
        logic [CH-1:0] cur, pre, evt;
        int n;
        samp.push_back(bus.iSig);
        n = samp.size();
`ifdef EDGE_DEBOUNCE_EN
        begin
            logic [CH-1:0] s2v;
            s2v     = (n >= 3) ? samp[n-3] : '0;
            cur     = db_lvl;
            pre     = db_prev;
            db_prev = db_lvl;
            for (int i = 0; i < CH; i++) begin
                if (n <= SEEDN) begin
                    db_lvl[i] = s2v[i];
                    db_run[i] = 0;
                end else if (s2v[i] != db_lvl[i]) begin
                    db_run[i]++;
                    if (db_run[i] == DBN) begin
                        db_lvl[i] = s2v[i];
                        db_run[i] = 0;
                    end
                end else begin
                    db_run[i] = 0;
                end
            end
        end
`else
        cur = (n >= 3) ? samp[n-3] : '0;
        pre = (n >= 4) ? samp[n-4] : '0;
`endif
        evt = (n > SEEDN) ? ((cur & ~pre & bus.iEdge_pos) | (~cur & pre & bus.iEdge_neg)) : '0;
        m_any   = |m_sticky;
        m_pulse = evt;
        for (int i = 0; i < CH; i++) begin
            if (evt[i])
                ext_left[i] = (bus.iDelay_time == '0) ? 1 : int'(bus.iDelay_time);
            else if (ext_left[i] > 0)
                ext_left[i]--;
            if (bus.iClear[i])
                m_cnt[i] = evt[i] ? CW'(1) : '0;
            else if (evt[i] && m_cnt[i] != CW'(255))
                m_cnt[i] = m_cnt[i] + CW'(1);
        end
        m_sticky = evt | (m_sticky & ~bus.iClear);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [CH-1:0]    ee;
        logic [CH*CW-1:0] ec;
        if (!rst_n) begin
            check("rst_pulse",  bus.oPulse, '0);
            check("rst_ext",    bus.oExt_pulse, '0);
            check("rst_sticky", bus.oSticky, '0);
            check("rst_cnt",    bus.oEvt_cnt, '0);
            check("rst_any",    bus.oAny_event, '0);
        end else begin
            for (int i = 0; i < CH; i++) begin
                ee[i] = (ext_left[i] > 0);
                ec[i*CW +: CW] = m_cnt[i];
            end
            check("pulse",  bus.oPulse, m_pulse);
            check("ext",    bus.oExt_pulse, ee);
            check("dbg",    bus.oDbg_stretch, ee);
            check("sticky", bus.oSticky, m_sticky);
            check("cnt",    bus.oEvt_cnt, ec);
            check("any",    bus.oAny_event, m_any);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic win(input int ch, input int steps, output int np, output int ne);
        np = 0;
        ne = 0;
        for (int j = 0; j < steps; j++) begin
            step();
            np += int'(bus.oPulse[ch]);
            ne += int'(bus.oExt_pulse[ch]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int np, ne, np2, ne2, tp;
        bus.iSig        = '0;
        bus.iEdge_pos   = '0;
        bus.iEdge_neg   = '0;
        bus.iDelay_time = 16'd1;
        bus.iClear      = '0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (6) step();

        // T1: ch0 rising edge, stretch 5
        bus.iEdge_pos[0] = 1'b1;
        bus.iDelay_time  = 16'd5;
        bus.iSig[0]      = 1'b1;
        step();
        step();
        check("t1_early", bus.oPulse[0], 1'b0);
        step();
        check("t1_pulse",  bus.oPulse[0], 1'b1);
        check("t1_ext",    bus.oExt_pulse[0], 1'b1);
        check("t1_sticky", bus.oSticky[0], 1'b1);
        check("t1_cnt",    bus.oEvt_cnt[7:0], 8'd1);
        check("t1_any0",   bus.oAny_event, 1'b0);
        check("t1_others", bus.oPulse[CH-1:1], '0);
        step();
        check("t1_pulse_off", bus.oPulse[0], 1'b0);
        check("t1_any1",      bus.oAny_event, 1'b1);
        ne = int'(bus.oExt_pulse[0]) + 1;
        win(0, 8, np2, ne2);
        check("t1_ext_len", 64'(ne + ne2), 64'd5);

        // T2: ch1 both edges then falling only
        bus.iEdge_pos[1] = 1'b1;
        bus.iEdge_neg[1] = 1'b1;
        bus.iSig[1] = 1'b1;
        win(1, 10, np, ne);
        bus.iSig[1] = 1'b0;
        win(1, 10, np2, ne2);
        check("t2_both_pulses", 64'(np + np2), 64'd2);
        check("t2_cnt2", bus.oEvt_cnt[15:8], 8'd2);
        bus.iEdge_pos[1] = 1'b0;
        bus.iSig[1] = 1'b1;
        win(1, 10, np, ne);
        bus.iSig[1] = 1'b0;
        win(1, 10, np2, ne2);
        check("t2_neg_pulses", 64'(np + np2), 64'd1);
        check("t2_cnt3", bus.oEvt_cnt[15:8], 8'd3);

        // T3: ch2 retrigger extends stretch; zero delay gives one cycle
        bus.iEdge_pos[2] = 1'b1;
        bus.iEdge_neg[2] = 1'b1;
        bus.iDelay_time  = 16'd10;
        bus.iSig[2] = 1'b1;
        win(2, 4, np, ne);
        bus.iSig[2] = 1'b0;
        win(2, 20, np2, ne2);
        check("t3_pulses",  64'(np + np2), 64'd2);
        check("t3_ext_len", 64'(ne + ne2), 64'd14);
        bus.iDelay_time = 16'd0;
        bus.iSig[2] = 1'b1;
        win(2, 8, np, ne);
        check("t3_d0_pulse", 64'(np), 64'd1);
        check("t3_d0_ext",   64'(ne), 64'd1);

        // T4: ch3 clear coinciding with event, then clear alone
        bus.iEdge_pos[3] = 1'b1;
        bus.iSig[3] = 1'b1;
        step();
        step();
        bus.iClear[3] = 1'b1;
        step();
        check("t4_sticky_hold", bus.oSticky[3], 1'b1);
        check("t4_cnt_one",     bus.oEvt_cnt[31:24], 8'd1);
        step();
        check("t4_sticky_clr", bus.oSticky[3], 1'b0);
        check("t4_cnt_clr",    bus.oEvt_cnt[31:24], 8'd0);
        bus.iClear[3] = 1'b0;

        // T5: ch4 saturation, then reset with ch5 held high
        bus.iEdge_pos[4] = 1'b1;
        bus.iEdge_neg[4] = 1'b1;
        bus.iDelay_time  = 16'd1;
        for (int j = 0; j < 300; j++) begin
            bus.iSig[4] = ~bus.iSig[4];
            step();
        end
        repeat (4) step();
        check("t5_sat", bus.oEvt_cnt[39:32], 8'd255);
        for (int j = 0; j < 6; j++) begin
            bus.iSig[4] = ~bus.iSig[4];
            step();
        end
        repeat (4) step();
        check("t5_sat_hold", bus.oEvt_cnt[39:32], 8'd255);
        bus.iSig[5]      = 1'b1;
        bus.iEdge_pos[5] = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("t5_async_sticky", bus.oSticky, '0);
        check("t5_async_any",    bus.oAny_event, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        win(5, 10, np, ne);
        check("t5_seed_nopulse", 64'(np), 64'd0);

        // T6: ch6 two-cycle glitch, then held change latency
        bus.iEdge_pos[6] = 1'b1;
        bus.iEdge_neg[6] = 1'b1;
        bus.iSig[6] = 1'b1;
        step();
        step();
        bus.iSig[6] = 1'b0;
        win(6, 12, np, ne);
`ifdef EDGE_DEBOUNCE_EN
        check("t6_glitch", 64'(np), 64'd0);
`else
        check("t6_glitch", 64'(np), 64'd2);
`endif
        bus.iSig[6] = 1'b1;
        tp = -1;
        for (int j = 0; j < 8; j++) begin
            step();
            if (bus.oPulse[6] && tp < 0) tp = j;
        end
        check("t6_latency", 64'(tp), 64'(PULSE_AT));

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            if (c % 64 == 0) begin
                bus.iEdge_pos = CH'($urandom);
                bus.iEdge_neg = CH'($urandom);
            end
            if ($urandom_range(0, 3) == 0) bus.iDelay_time = DW'($urandom_range(0, 12));
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 5) == 0) bus.iSig[i] = ~bus.iSig[i];
                bus.iClear[i] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step();
        end
        bus.iClear = '0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
